// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The master side issues requests; the slave side grants and returns data.
interface if_stage_if #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned INST_LEN = 32
) ();
   logic                req;
   logic [XLEN-1:0]     addr;
   logic                gnt;
   logic                rvalid;
   logic [INST_LEN-1:0] rdata;

   modport master (output req, output addr, input gnt, input rvalid, input rdata);
   modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, registered decode entry
// backed by a one-entry skid buffer, redirects drop the in-flight response.
module if_stage #(
   parameter int unsigned      XLEN     = 64,
   parameter int unsigned      INST_LEN = 32,
   parameter logic [XLEN-1:0]  RESET_PC = XLEN'(64'h8000_0000)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                is_jump_i,
   input  logic [XLEN-1:0]     pc_next_i,
   input  logic                stall_i,
   if_stage_if.master          imem,
   output logic [XLEN-1:0]     pc_if_o,
   output logic [INST_LEN-1:0] instr_if_o,
   output logic                valid_if_o
);

   typedef enum logic [0:0] {ST_REQ = 1'b0, ST_WAIT = 1'b1} state_t;

   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(2'b11));
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(3'd4);

   state_t              state_r;
   logic [XLEN-1:0]     pc_r;
   logic [XLEN-1:0]     inflight_pc_r;
   logic                drop_r;
   logic [XLEN-1:0]     out_pc_r;
   logic [INST_LEN-1:0] out_instr_r;
   logic                out_valid_r;
   logic [XLEN-1:0]     skid_pc_r;
   logic [INST_LEN-1:0] skid_instr_r;
   logic                skid_valid_r;

   logic req_s;
   logic handshake_s;
   logic response_s;
   logic deliver_s;
   logic consume_s;

   // A full skid buffer blocks new requests, so it can never overflow.
   assign req_s       = (state_r == ST_REQ) && !skid_valid_r;
   assign handshake_s = req_s && imem.gnt;
   assign response_s  = (state_r == ST_WAIT) && imem.rvalid;
   assign deliver_s   = response_s && !drop_r;
   assign consume_s   = out_valid_r && !stall_i;

   assign imem.req   = req_s;
   assign imem.addr  = pc_r & ALIGN_MASK;
   assign pc_if_o    = out_pc_r;
   assign instr_if_o = out_instr_r;
   assign valid_if_o = out_valid_r;

   // Fetch FSM: fetch PC, in-flight PC and drop flag for redirected requests.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_REQ;
         pc_r          <= RESET_PC;
         inflight_pc_r <= {XLEN{1'b0}};
         drop_r        <= 1'b0;
      end else if (is_jump_i) begin
         pc_r <= pc_next_i & ALIGN_MASK;
         if (handshake_s || ((state_r == ST_WAIT) && !imem.rvalid)) begin
            drop_r  <= 1'b1;
            state_r <= ST_WAIT;
         end else begin
            drop_r  <= 1'b0;
            state_r <= ST_REQ;
         end
      end else begin
         case (state_r)
            ST_REQ: begin
               if (handshake_s) begin
                  inflight_pc_r <= pc_r;
                  pc_r          <= pc_r + PC_STEP;
                  state_r       <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem.rvalid) begin
                  drop_r  <= 1'b0;
                  state_r <= ST_REQ;
               end
            end
            default: begin
               drop_r  <= 1'b0;
               state_r <= ST_REQ;
            end
         endcase
      end
   end

   // Decode-facing entry and skid buffer: refill order is skid, then response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_pc_r     <= {XLEN{1'b0}};
         out_instr_r  <= {INST_LEN{1'b0}};
         out_valid_r  <= 1'b0;
         skid_pc_r    <= {XLEN{1'b0}};
         skid_instr_r <= {INST_LEN{1'b0}};
         skid_valid_r <= 1'b0;
      end else if (is_jump_i) begin
         out_valid_r  <= 1'b0;
         skid_valid_r <= 1'b0;
      end else if (consume_s) begin
         if (skid_valid_r) begin
            out_pc_r     <= skid_pc_r;
            out_instr_r  <= skid_instr_r;
            out_valid_r  <= 1'b1;
            skid_valid_r <= 1'b0;
         end else if (deliver_s) begin
            out_pc_r    <= inflight_pc_r;
            out_instr_r <= imem.rdata;
            out_valid_r <= 1'b1;
         end else begin
            out_valid_r <= 1'b0;
         end
      end else if (deliver_s) begin
         if (!out_valid_r) begin
            out_pc_r    <= inflight_pc_r;
            out_instr_r <= imem.rdata;
            out_valid_r <= 1'b1;
         end else begin
            skid_pc_r    <= inflight_pc_r;
            skid_instr_r <= imem.rdata;
            skid_valid_r <= 1'b1;
         end
      end
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: XLEN, default 64, datapath and PC width.
REQ-002 Parameter: INST_LEN, default 32, instruction width.
REQ-003 Parameter: RESET_PC, default 64'h8000_0000, first fetch address after reset.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 is_jump_i  in  1  one-cycle redirect pulse from execute stage.
REQ-007 pc_next_i  in  XLEN  redirect target, qualified by is_jump_i.
REQ-008 stall_i  in  1  IF/ID hold from hazard logic; output entry not consumed while high.
REQ-009 imem_req_o  out  1  fetch request valid.
REQ-010 imem_addr_o  out  XLEN  fetch address, meaningful while imem_req_o high.
REQ-011 imem_gnt_i  in  1  request accepted this cycle (req&&gnt = handshake).
REQ-012 imem_rvalid_i  in  1  response valid, single cycle, at least 1 cycle after the grant.
REQ-013 imem_rdata_i  in  INST_LEN  fetched instruction, qualified by imem_rvalid_i.
REQ-014 pc_if_o  out  XLEN  PC of the instruction presented to decode.
REQ-015 instr_if_o  out  INST_LEN  instruction presented to decode.
REQ-016 valid_if_o  out  1  pc_if_o/instr_if_o hold a live instruction.

Function
REQ-017 State: fetch PC register pc_r; in-flight PC register; FSM {REQ, WAIT}; drop flag; output entry (pc, instr, valid); one-entry skid buffer (pc, instr, valid).
REQ-018 At most one request outstanding: a new request is never issued in WAIT.
REQ-019 REQ: imem_req_o = !skid_valid; imem_addr_o = {pc_r[XLEN-1:2], 2'b00}.
REQ-020 imem_addr_o and imem_req_o held stable while req && !gnt, unless a redirect occurs.
REQ-021 On handshake: in-flight PC <= pc_r, pc_r <= pc_r + 4 (mod 2^XLEN wrap), FSM -> WAIT.
REQ-022 WAIT, rvalid with drop flag set: data discarded, drop cleared, FSM -> REQ.
REQ-023 WAIT, rvalid, drop clear: {in-flight PC, rdata} written to the output entry if it is empty or consumed this cycle, else to the skid buffer; FSM -> REQ.
REQ-024 Output entry consumed in any cycle with valid_if_o && !stall_i; on consumption it is refilled from skid if skid_valid (skid cleared), else from a same-cycle response, else cleared.
REQ-025 Skid buffer never overflows: by REQ-018/REQ-019 it fills only from the single in-flight response and no request issues while it is full.
REQ-026 Redirect (is_jump_i=1) has priority over stall, handshake and response.
REQ-026a On redirect: pc_r <= {pc_next_i[XLEN-1:2],2'b00}; output entry and skid cleared.
REQ-027 Redirect with a request outstanding (FSM WAIT without rvalid, or handshake same cycle): drop flag set; FSM WAIT.
REQ-028 Redirect in the same cycle as a non-dropped rvalid: the response is discarded, FSM -> REQ.
REQ-029 Redirect in the same cycle as a handshake: pc_r takes the redirect target, not pc_r+4.
REQ-030 Outputs are registered; no combinational path from is_jump_i, stall_i or imem_rdata_i to pc_if_o/instr_if_o/valid_if_o.
REQ-031 Latency: handshake at cycle N with rvalid at N+k -> valid_if_o high at N+k+1 when not blocked.

Reset
REQ-032 While rst high (asynchronous): pc_r=RESET_PC; FSM=REQ; drop=0; skid_valid=0; valid_if_o=0; pc_if_o=0; instr_if_o=0.
REQ-033 The first cycle after rst deasserts issues imem_req_o=1 at RESET_PC.
REQ-034 A response belonging to a request issued before a reset is ignored.
REQ-035 Reset asserted mid-WAIT returns to REQ with no pending drop.

Verification
REQ-036 Reset release, gnt=1 same cycle, rvalid 1 cycle later with 0x00000013 -> pc_if_o=0x8000_0000, instr_if_o=0x00000013, valid_if_o=1; next request at 0x8000_0004.
REQ-037 gnt held 0 for 3 cycles -> imem_req_o=1 and imem_addr_o=0x8000_0000 stable throughout; single handshake.
REQ-038 stall_i=1 with valid_if_o=1; response for 0x8000_0004 arrives -> goes to skid, imem_req_o=0, output unchanged; stall_i drops -> 0x8000_0004 presented next cycle, requests resume at 0x8000_0008.
REQ-039 is_jump_i=1 with pc_next_i=0x8000_0100 while in WAIT -> valid_if_o=0 next cycle; the late response is dropped; next request address 0x8000_0100.
REQ-040 is_jump_i and handshake same cycle, pc_next_i=0x8000_0203 -> in-flight response dropped; next address 0x8000_0200.
REQ-041 Reset asserted mid-WAIT with stale rvalid after release -> stale data never reaches valid_if_o; fetch restarts at 0x8000_0000.
